// File: rtl/cam_capture_pkg.sv
// Shared frame-buffer geometry and colour layout for the capture writer and
// the colour-processing reader.
package cam_capture_pkg;

    // Camera geometry and decimation
    localparam int c_cam_cols    = 640;
    localparam int c_cam_rows    = 480;
    localparam int c_dec_log2    = 3;

    // Buffer image geometry
    localparam int c_img_cols    = c_cam_cols >> c_dec_log2;
    localparam int c_img_rows    = c_cam_rows >> c_dec_log2;
    localparam int c_img_pxls    = c_img_cols * c_img_rows;
    localparam int c_nb_img_pxls = 13;

    // Buffer word layout: R[11:8] G[7:4] B[3:0]
    localparam int c_nb_buf_red   = 4;
    localparam int c_nb_buf_green = 4;
    localparam int c_nb_buf_blue  = 4;
    localparam int c_nb_buf       = c_nb_buf_red + c_nb_buf_green + c_nb_buf_blue;
    localparam int c_msb_red      = c_nb_buf - 1;
    localparam int c_msb_green    = c_msb_red - c_nb_buf_red;
    localparam int c_msb_blue     = c_msb_green - c_nb_buf_green;

    typedef enum logic {
        WAIT_FRAME = 1'b0,
        CAPTURE    = 1'b1
    } cap_state_t;

    // Pack a red nibble and the camera's {G,B} byte into one buffer word
    function automatic logic [c_nb_buf-1:0] pack_pxl(
        input logic [c_nb_buf_red-1:0]                  red,
        input logic [c_nb_buf_green+c_nb_buf_blue-1:0]  gb
    );
        return {red, gb};
    endfunction

endpackage

// File: rtl/cam_capture_sync_edge.sv
// Two-flop synchronizer with a third stage that aligns the level output with
// registered rise/fall strobes, so data and edges come out in the same cycle.
module cam_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o,
    output logic [W-1:0] fall_o
);

    logic [W-1:0] s1_q, s2_q, s3_q, rise_q, fall_q;

    // Synchronize, delay one more stage and register the edge strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
            fall_q <= ~s2_q & s3_q;
        end
    end

    assign sync_o = s3_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/cam_capture.sv
// Camera capture writer: samples an RGB444 byte stream, decimates it by
// 2^DEC_LOG2 in both axes and writes 12-bit pixels into the frame buffer.
// Geometry parameters default to the package values.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int CAM_COLS = c_cam_cols,
    parameter int CAM_ROWS = c_cam_rows,
    parameter int DEC_LOG2 = c_dec_log2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     capture_en_i,
    input  logic                     cam_pclk_i,
    input  logic                     cam_vsync_i,
    input  logic                     cam_href_i,
    input  logic [7:0]               cam_data_i,
    output logic                     buf_we_o,
    output logic [c_nb_img_pxls-1:0] buf_addr_o,
    output logic [c_nb_buf-1:0]      buf_pxl_o,
    output logic                     frame_done_o,
    output logic                     frame_err_o
);

    localparam int IMG_PXLS = (CAM_COLS >> DEC_LOG2) * (CAM_ROWS >> DEC_LOG2);
    localparam int NB_COL   = $clog2(CAM_COLS + 1);
    localparam int NB_ROW   = $clog2(CAM_ROWS + 1);

    localparam logic [NB_COL-1:0]        COL_MAX = NB_COL'(CAM_COLS);
    localparam logic [NB_ROW-1:0]        ROW_MAX = NB_ROW'(CAM_ROWS);
    localparam logic [c_nb_img_pxls-1:0] PXL_MAX = c_nb_img_pxls'(IMG_PXLS);

    // Synchronized camera signals
    logic       pclk_sync, pclk_rise, pclk_fall;
    logic       vsync_sync, vsync_rise, vsync_fall;
    logic       href_sync, href_rise, href_fall;
    logic [7:0] data_sync, data_rise, data_fall;

    cam_sync_edge #(.W(1)) u_sync_pclk (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cam_pclk_i),
        .sync_o (pclk_sync),
        .rise_o (pclk_rise),
        .fall_o (pclk_fall)
    );

    cam_sync_edge #(.W(1)) u_sync_vsync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cam_vsync_i),
        .sync_o (vsync_sync),
        .rise_o (vsync_rise),
        .fall_o (vsync_fall)
    );

    cam_sync_edge #(.W(1)) u_sync_href (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cam_href_i),
        .sync_o (href_sync),
        .rise_o (href_rise),
        .fall_o (href_fall)
    );

    cam_sync_edge #(.W(8)) u_sync_data (
        .clk    (clk),
        .rst    (rst),
        .d_i    (cam_data_i),
        .sync_o (data_sync),
        .rise_o (data_rise),
        .fall_o (data_fall)
    );

    // Edge/level outputs the capture logic has no use for
    logic unused_sync;
    assign unused_sync = ^{pclk_sync, pclk_fall, vsync_sync, href_rise,
                           data_rise, data_fall};

    // Capture state
    cap_state_t                 state_q;
    logic                       phase_q;
    logic [NB_COL-1:0]          col_q;
    logic [NB_ROW-1:0]          row_q;
    logic [c_nb_img_pxls-1:0]   addr_q;
    logic [c_nb_buf_red-1:0]    red_q;

    // Registered outputs
    logic                       buf_we_q;
    logic [c_nb_img_pxls-1:0]   buf_addr_q;
    logic [c_nb_buf-1:0]        buf_pxl_q;
    logic                       frame_done_q;
    logic                       frame_err_q;

    // A completed pixel is kept only on the decimation grid, inside the
    // camera frame, and while the buffer still has room
    logic keep_pxl;
    assign keep_pxl = (col_q[DEC_LOG2-1:0] == '0) && (row_q[DEC_LOG2-1:0] == '0) &&
                      (col_q < COL_MAX) && (row_q < ROW_MAX) && (addr_q < PXL_MAX);

    // Frame FSM: wait for vsync fall, assemble byte pairs into pixels,
    // track line/column position and report the frame outcome on vsync rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_FRAME;
            phase_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            addr_q       <= '0;
            red_q        <= '0;
            buf_we_q     <= 1'b0;
            buf_addr_q   <= '0;
            buf_pxl_q    <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            buf_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                WAIT_FRAME: begin
                    if (vsync_fall && capture_en_i) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (vsync_rise) begin
                        // End of frame takes priority over a coincident line end
                        if (addr_q == PXL_MAX) frame_done_q <= 1'b1;
                        else                   frame_err_q  <= 1'b1;
                        state_q <= WAIT_FRAME;
                    end else if (href_fall) begin
                        // A dangling first byte is dropped with the phase reset
                        col_q   <= '0;
                        phase_q <= 1'b0;
                        if (row_q != ROW_MAX) row_q <= row_q + NB_ROW'(1);
                    end else if (pclk_rise && href_sync) begin
                        if (!phase_q) begin
                            red_q   <= data_sync[c_nb_buf_red-1:0];
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            if (keep_pxl) begin
                                buf_pxl_q  <= pack_pxl(red_q, data_sync);
                                buf_addr_q <= addr_q;
                                buf_we_q   <= 1'b1;
                                addr_q     <= addr_q + c_nb_img_pxls'(1);
                            end
                            if (col_q != COL_MAX) col_q <= col_q + NB_COL'(1);
                        end
                    end
                end
                default: state_q <= WAIT_FRAME;
            endcase
        end
    end

    assign buf_we_o     = buf_we_q;
    assign buf_addr_o   = buf_addr_q;
    assign buf_pxl_o    = buf_pxl_q;
    assign frame_done_o = frame_done_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture. A reduced camera geometry (32x16, decimate by 4,
// 8x4 = 32 buffer pixels) keeps every frame short; the reference model builds
// the expected write list from the stream rules with plain arithmetic.
module tb_cam_capture;

    localparam int CAM_COLS = 32;
    localparam int CAM_ROWS = 16;
    localparam int DEC_LOG2 = 2;
    localparam int DECF     = 1 << DEC_LOG2;
    localparam int IMG_PXLS = (CAM_COLS / DECF) * (CAM_ROWS / DECF);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        capture_en = 1'b1;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b1;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        buf_we;
    logic [12:0] buf_addr;
    logic [11:0] buf_pxl;
    logic        frame_done;
    logic        frame_err;

    cam_capture #(
        .CAM_COLS (CAM_COLS),
        .CAM_ROWS (CAM_ROWS),
        .DEC_LOG2 (DEC_LOG2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .capture_en_i (capture_en),
        .cam_pclk_i   (cam_pclk),
        .cam_vsync_i  (cam_vsync),
        .cam_href_i   (cam_href),
        .cam_data_i   (cam_data),
        .buf_we_o     (buf_we),
        .buf_addr_o   (buf_addr),
        .buf_pxl_o    (buf_pxl),
        .frame_done_o (frame_done),
        .frame_err_o  (frame_err)
    );

    always #5 clk = ~clk;

    typedef logic [24:0] wr_t;   // {addr[12:0], pxl[11:0]}

    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_cnt = 0;
    int  err_cnt  = 0;
    int  checks   = 0;
    int  errors   = 0;

    // Observe the write port and the frame pulses away from the active edge
    always @(negedge clk) begin
        if (buf_we)     got_q.push_back({buf_addr, buf_pxl});
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        repeat (8) @(negedge clk);
        cam_vsync = 1'b0;
        exp_q.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // One camera line; the model appends every pixel the writer should keep
    task automatic drive_line(input int l, input int nbytes, input bit pat, input bit mdl);
        logic [7:0] b;
        logic [7:0] r;
        r = 8'h00;
        cam_href = 1'b1;
        for (int k = 0; k < nbytes; k++) begin
            if (pat) b = (k % 2 == 0) ? 8'(l & 15) : {4'(k / 2), 4'h5};
            else     b = 8'($urandom);
            send_byte(b);
            if (k % 2 == 0) r = b;
            else if (mdl && l < CAM_ROWS && (k / 2) < CAM_COLS && (l % DECF) == 0 &&
                     ((k / 2) % DECF) == 0 && exp_q.size() < IMG_PXLS)
                exp_q.push_back({13'(exp_q.size()), r[3:0], b});
        end
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++; if (buf_we !== 1'b0)       begin errors++; $display("FAIL reset_we got %b want 0", buf_we); end
        checks++; if (buf_addr !== 13'd0)    begin errors++; $display("FAIL reset_addr got %0d want 0", buf_addr); end
        checks++; if (buf_pxl !== 12'h000)   begin errors++; $display("FAIL reset_pxl got %h want 000", buf_pxl); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
        // vsync is high out of reset; its edge must not produce a pulse
        checks++; if (done_cnt + err_cnt !== 0) begin errors++; $display("FAIL reset_pulse got %0d want 0", done_cnt + err_cnt); end
    endtask

    task automatic test_latency();
        logic [7:0] b0, b1;
        logic       we_seen [1:5];
        logic [12:0] a4;
        logic [11:0] p4, p5;
        int          eb;
        eb = err_cnt;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        frame_start();
        cam_href = 1'b1;
        send_byte(b0);
        cam_data = b1;
        cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        a4 = '0; p4 = '0; p5 = '0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            we_seen[k] = buf_we;
            if (k == 4) begin a4 = buf_addr; p4 = buf_pxl; end
            if (k == 5) p5 = buf_pxl;
        end
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (we_seen[k] !== (k == 4)) begin errors++; $display("FAIL latency_we cycle %0d got %b want %b", k, we_seen[k], (k == 4)); end
        end
        checks++; if (a4 !== 13'd0)           begin errors++; $display("FAIL latency_addr got %0d want 0", a4); end
        checks++; if (p4 !== {b0[3:0], b1})   begin errors++; $display("FAIL latency_pxl got %h want %h", p4, {b0[3:0], b1}); end
        checks++; if (p5 !== {b0[3:0], b1})   begin errors++; $display("FAIL latency_hold got %h want %h", p5, {b0[3:0], b1}); end
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (6) @(negedge clk);
        frame_end();
        checks++; if (err_cnt - eb !== 1)     begin errors++; $display("FAIL latency_err got %0d want 1", err_cnt - eb); end
    endtask

    task automatic test_full_frame();
        int wb, db, eb;
        wb = got_q.size(); db = done_cnt; eb = err_cnt;
        frame_start();
        for (int l = 0; l < CAM_ROWS; l++) drive_line(l, 2 * CAM_COLS, 1'b1, 1'b1);
        frame_end();
        checks++; if (got_q.size() - wb !== IMG_PXLS) begin errors++; $display("FAIL full_count got %0d want %0d", got_q.size() - wb, IMG_PXLS); end
        for (int i = 0; i < exp_q.size() && wb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[wb + i] !== exp_q[i]) begin errors++; $display("FAIL full_wr[%0d] got %h want %h", i, got_q[wb + i], exp_q[i]); end
        end
        // Image (1,0) is camera (4,0): R=4 G=0 B=5; image (1,1) is camera (4,4)
        if (got_q.size() - wb > 9) begin
            checks++; if (got_q[wb + 8] !== {13'd8, 12'h405}) begin errors++; $display("FAIL full_px8 got %h want %h", got_q[wb + 8], {13'd8, 12'h405}); end
            checks++; if (got_q[wb + 9] !== {13'd9, 12'h445}) begin errors++; $display("FAIL full_px9 got %h want %h", got_q[wb + 9], {13'd9, 12'h445}); end
        end
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL full_done got %0d want 1", done_cnt - db); end
        checks++; if (err_cnt - eb !== 0)  begin errors++; $display("FAIL full_err got %0d want 0", err_cnt - eb); end
    endtask

    // Random-content frame with configurable line count and bytes per line
    task automatic test_random_frame(input string name, input int nlines, input int nbytes,
                                     input int want_wr, input int want_done, input int want_err);
        int wb, db, eb;
        wb = got_q.size(); db = done_cnt; eb = err_cnt;
        frame_start();
        for (int l = 0; l < nlines; l++) drive_line(l, nbytes, 1'b0, 1'b1);
        frame_end();
        checks++; if (got_q.size() - wb !== want_wr) begin errors++; $display("FAIL %s_count got %0d want %0d", name, got_q.size() - wb, want_wr); end
        for (int i = 0; i < exp_q.size() && wb + i < got_q.size(); i++) begin
            checks++;
            if (got_q[wb + i] !== exp_q[i]) begin errors++; $display("FAIL %s_wr[%0d] got %h want %h", name, i, got_q[wb + i], exp_q[i]); end
        end
        checks++; if (done_cnt - db !== want_done) begin errors++; $display("FAIL %s_done got %0d want %0d", name, done_cnt - db, want_done); end
        checks++; if (err_cnt - eb !== want_err)   begin errors++; $display("FAIL %s_err got %0d want %0d", name, err_cnt - eb, want_err); end
    endtask

    task automatic test_capture_en();
        int wb, db, eb;
        wb = got_q.size(); db = done_cnt; eb = err_cnt;
        capture_en = 1'b0;
        frame_start();
        for (int l = 0; l < CAM_ROWS; l++) begin
            if (l == CAM_ROWS / 2) capture_en = 1'b1;
            drive_line(l, 2 * CAM_COLS, 1'b0, 1'b0);
        end
        frame_end();
        checks++; if (got_q.size() - wb !== 0)          begin errors++; $display("FAIL en_off_writes got %0d want 0", got_q.size() - wb); end
        checks++; if (done_cnt - db + err_cnt - eb !== 0) begin errors++; $display("FAIL en_off_pulse got %0d want 0", done_cnt - db + err_cnt - eb); end
        test_random_frame("en_on", CAM_ROWS, 2 * CAM_COLS, IMG_PXLS, 1, 0);
    endtask

    task automatic test_reset_mid();
        int wb, db, eb;
        frame_start();
        for (int l = 0; l < 9; l++) drive_line(l, 2 * CAM_COLS, 1'b0, 1'b1);
        cam_href = 1'b1;
        send_byte(8'($urandom));
        rst = 1'b1;
        #1;
        checks++; if (buf_we !== 1'b0)     begin errors++; $display("FAIL rstmid_we got %b want 0", buf_we); end
        checks++; if (buf_addr !== 13'd0)  begin errors++; $display("FAIL rstmid_addr got %0d want 0", buf_addr); end
        checks++; if (buf_pxl !== 12'h000) begin errors++; $display("FAIL rstmid_pxl got %h want 000", buf_pxl); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wb = got_q.size(); db = done_cnt; eb = err_cnt;
        send_byte(8'($urandom));
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (6) @(negedge clk);
        for (int l = 10; l < CAM_ROWS; l++) drive_line(l, 2 * CAM_COLS, 1'b0, 1'b0);
        frame_end();
        checks++; if (got_q.size() - wb !== 0)            begin errors++; $display("FAIL rstmid_writes got %0d want 0", got_q.size() - wb); end
        checks++; if (done_cnt - db + err_cnt - eb !== 0) begin errors++; $display("FAIL rstmid_pulse got %0d want 0", done_cnt - db + err_cnt - eb); end
        test_random_frame("after_rst", CAM_ROWS, 2 * CAM_COLS, IMG_PXLS, 1, 0);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_full_frame();
        test_random_frame("short", CAM_ROWS / 2, 2 * CAM_COLS, IMG_PXLS / 2, 0, 1);
        test_random_frame("odd_byte", CAM_ROWS, 2 * CAM_COLS + 1, IMG_PXLS, 1, 0);
        test_random_frame("oversize", CAM_ROWS + 4, 2 * CAM_COLS + 16, IMG_PXLS, 1, 0);
        test_capture_en();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
